// File: rtl/fifo_pkg.sv
// fifo_pkg: shared status bundle and width helper for the synchronous FIFO.
package fifo_pkg;
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: flop-array storage with one synchronous write port and one asynchronous read port.
module fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: single-clock FIFO with occupancy count, almost flags, sticky over/underflow and flush.
// Define FIFO_FWFT_EN for a first-word-fall-through output instead of the registered 1-cycle read.
module fifo_sync_flags
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = fifo_cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             fifo_flush,
    input  logic             fifo_write,
    input  logic [WIDTH-1:0] fifo_data_in,
    input  logic             fifo_read,
    output logic [WIDTH-1:0] fifo_data_out,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic             fifo_almost_full,
    output logic             fifo_almost_empty,
    output logic [CNT_W-1:0] fifo_count,
    output logic             fifo_overflow,
    output logic             fifo_underflow
);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, unf_q, rd_ok, wr_ok;
    logic [WIDTH-1:0] rdata;
    fifo_status_t     st;

    assign st = '{full:         count_q == DEPTH_C,
                  empty:        count_q == '0,
                  almost_full:  count_q >= AF_C,
                  almost_empty: count_q <= AE_C,
                  overflow:     ovf_q,
                  underflow:    unf_q};

    // a full FIFO still takes a write when the same edge pops a word
    assign rd_ok    = fifo_read & ~st.empty;
    assign wr_ok    = fifo_write & (~st.full | rd_ok);
    assign wr_ptr_d = wr_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    assign rd_ptr_d = rd_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    assign count_d  = count_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);

    fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (wr_ok & ~fifo_flush),
        .waddr (wr_ptr_q),
        .wdata (fifo_data_in),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else if (fifo_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (fifo_write & ~wr_ok) ovf_q <= 1'b1;
            if (fifo_read & st.empty) unf_q <= 1'b1;
        end
    end

`ifdef FIFO_FWFT_EN
    assign fifo_data_out = st.empty ? '0 : rdata;
`else
    logic [WIDTH-1:0] dout_q;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) dout_q <= '0;
        else if (~fifo_flush & rd_ok) dout_q <= rdata;
    end

    assign fifo_data_out = dout_q;
`endif

    assign fifo_full         = st.full;
    assign fifo_empty        = st.empty;
    assign fifo_almost_full  = st.almost_full;
    assign fifo_almost_empty = st.almost_empty;
    assign fifo_count        = count_q;
    assign fifo_overflow     = st.overflow;
    assign fifo_underflow    = st.underflow;
endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb_fifo_sync_flags: table vectors plus corner sequences against a queue reference model and read scoreboard.
// Works for both the default build and FIFO_FWFT_EN.
module tb_fifo_sync_flags;
    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        fifo_flush = 1'b0, fifo_write = 1'b0, fifo_read = 1'b0;
    logic [15:0] fifo_data_in = '0, fifo_data_out;
    logic        fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty;
    logic [4:0]  fifo_count;
    logic        fifo_overflow, fifo_underflow;

    int          nchk = 0, nerr = 0;
    logic [15:0] mdl[$];
    logic [15:0] sb[$];
    logic [15:0] last = '0;
    logic        m_ovf = 1'b0, m_unf = 1'b0;

    typedef struct {
        logic        fl, wr, rd;
        logic [15:0] din;
        int          cnt;
        logic        emp, ful, af, ae, ovf, unf;
    } vec_t;
    vec_t tbl[9];

    fifo_sync_flags dut (
        .clk(clk), .rst_(rst_), .fifo_flush(fifo_flush), .fifo_write(fifo_write),
        .fifo_data_in(fifo_data_in), .fifo_read(fifo_read), .fifo_data_out(fifo_data_out),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_almost_full(fifo_almost_full),
        .fifo_almost_empty(fifo_almost_empty), .fifo_count(fifo_count),
        .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", n, a, e);
        end
    endtask

    task automatic model_reset();
        mdl.delete();
        sb.delete();
        last  = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic check_all();
        int c;
        c = mdl.size();
        chk("count", 32'(fifo_count), 32'(c));
        chk("empty", 32'(fifo_empty), 32'(c == 0));
        chk("full", 32'(fifo_full), 32'(c == 16));
        chk("almost_full", 32'(fifo_almost_full), 32'(c >= 14));
        chk("almost_empty", 32'(fifo_almost_empty), 32'(c <= 2));
        chk("overflow", 32'(fifo_overflow), 32'(m_ovf));
        chk("underflow", 32'(fifo_underflow), 32'(m_unf));
`ifdef FIFO_FWFT_EN
        chk("dout_front", 32'(fifo_data_out), 32'(c > 0 ? mdl[0] : 16'h0));
`else
        chk("dout_hold", 32'(fifo_data_out), 32'(last));
`endif
    endtask

    task automatic step(input logic fl, input logic wr, input logic rd, input logic [15:0] din);
        logic rok, wok;
        fifo_flush = fl; fifo_write = wr; fifo_read = rd; fifo_data_in = din;
        rok = !fl && rd && mdl.size() > 0;
        wok = !fl && wr && (mdl.size() < 16 || rok);
        if (fl) begin
            mdl.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (wr && !wok) m_ovf = 1'b1;
            if (rd && mdl.size() == 0) m_unf = 1'b1;
            if (rok) sb.push_back(mdl.pop_front());
            if (wok) mdl.push_back(din);
        end
        #2;
`ifdef FIFO_FWFT_EN
        if (rok) chk("fwft_data", 32'(fifo_data_out), 32'(sb.pop_front()));
`endif
        @(posedge clk);
        #1;
        fifo_flush = 1'b0; fifo_write = 1'b0; fifo_read = 1'b0;
`ifndef FIFO_FWFT_EN
        if (rok) begin
            last = sb.pop_front();
            chk("read_data", 32'(fifo_data_out), 32'(last));
        end
`endif
        check_all();
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 16'h1111, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 16'h2222, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 16'h3333, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 16'h4444, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 16'h5555, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 16'h00AA, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_dout", 32'(fifo_data_out), 32'h0);
        check_all();
        rst_ = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].fl, tbl[i].wr, tbl[i].rd, tbl[i].din);
            chk($sformatf("v%0d_count", i), 32'(fifo_count), 32'(tbl[i].cnt));
            chk($sformatf("v%0d_flags", i),
                32'({fifo_empty, fifo_full, fifo_almost_full, fifo_almost_empty, fifo_overflow, fifo_underflow}),
                32'({tbl[i].emp, tbl[i].ful, tbl[i].af, tbl[i].ae, tbl[i].ovf, tbl[i].unf}));
        end

        // async reset mid-run, observed between edges
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 16'hC000 + 16'(i));
        #2;
        rst_ = 1'b0;
        #1;
        model_reset();
        chk("async_reset_dout", 32'(fifo_data_out), 32'h0);
        check_all();
        @(posedge clk);
        #1;
        rst_ = 1'b1;

        // fill to full, then overflow
        for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, 1'b0, 16'(i));
        step(1'b0, 1'b1, 1'b0, 16'hDEAD);
        chk("ovf_count", 32'(fifo_count), 32'd16);

        // full with simultaneous read+write: pointers wrap, order preserved
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 16'hBEEF + 16'(i));

        // drain and one extra read
        for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 1'b1, 16'h0);
        chk("unf_set", 32'(fifo_underflow), 32'd1);

        // empty read+write same edge, then read back
        step(1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 1'b1, 16'h00AA);
        step(1'b0, 1'b0, 1'b1, 16'h0);

        // count 5, flush with concurrent read+write
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 16'hA000 + 16'(i));
        step(1'b0, 1'b0, 1'b1, 16'h0);
        step(1'b0, 1'b1, 1'b0, 16'hA005);
        step(1'b1, 1'b1, 1'b1, 16'h5A5A);
        chk("flush_count", 32'(fifo_count), 32'd0);

        // reset asserted across a write edge: the write is lost
        fifo_write = 1'b1;
        fifo_data_in = 16'h7777;
        #2;
        rst_ = 1'b0;
        @(posedge clk);
        #1;
        rst_ = 1'b1;
        fifo_write = 1'b0;
        model_reset();
        check_all();
        step(1'b0, 1'b0, 1'b1, 16'h0);
        chk("lost_write_unf", 32'(fifo_underflow), 32'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
